// File: rtl/mario_enemy_contact_responder.sv
// Mario-side enemy contact responder: classifies stomp vs side hit and runs bounce, lives and game-over state.
// Optional SCORE_EN macro builds the saturating stomp score counter; otherwise score is tied to 0.
module mario_enemy_contact_responder #(
  parameter int CHARACTER_WIDTH = 42,
  parameter int SCREEN_WIDTH    = 640,
  parameter int LIVES_INIT      = 3,
  parameter int BOUNCE_TICKS    = 24,
  parameter int INVULN_TICKS    = 120,
  parameter int STOMP_POINTS    = 100
) (
  input  logic               movement_clock,
  input  logic               reset,
  input  logic signed [31:0] mario_x,
  input  logic signed [31:0] mario_y,
  input  logic signed [31:0] enemy_x,
  input  logic signed [31:0] enemy_y,
  input  logic               enemy_alive,
  output logic               stomp,
  output logic               bounce_up,
  output logic               invincible,
  output logic [3:0]         lives,
  output logic               game_over,
  output logic [13:0]        score
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    HURT   = 2'd2,
    DEAD   = 2'd3
  } state_e;

  localparam logic signed [31:0] CW = 32'(CHARACTER_WIDTH);
  localparam logic signed [31:0] SW = 32'(SCREEN_WIDTH);
  localparam logic [15:0] BOUNCE_LOAD = 16'(BOUNCE_TICKS - 1);
  localparam logic [15:0] INVULN_LOAD = 16'(INVULN_TICKS - 1);
  localparam logic [3:0]  LIVES_LOAD  = 4'(LIVES_INIT);

  state_e      state_q, state_d;
  logic        stomp_q, stomp_d;
  logic        bounce_q, bounce_d;
  logic        inv_q, inv_d;
  logic        go_q, go_d;
  logic [3:0]  lives_q, lives_d;
  logic [15:0] bounce_cnt_q, bounce_cnt_d;
  logic [15:0] inv_cnt_q, inv_cnt_d;

  logic hx, top_hit, side_hit, valid;

  // Box overlap terms, all signed pixel arithmetic.
  always_comb begin
    hx       = (mario_x + CW >= enemy_x) && (mario_x <= enemy_x + CW);
    top_hit  = hx && (mario_y + CW == enemy_y);
    side_hit = hx && (mario_y + CW > enemy_y) && (mario_y < enemy_y + CW);
    valid    = enemy_alive && (enemy_x < SW);
  end

  always_comb begin
    state_d      = state_q;
    stomp_d      = stomp_q;
    bounce_d     = bounce_q;
    inv_d        = inv_q;
    go_d         = go_q;
    lives_d      = lives_q;
    bounce_cnt_d = bounce_cnt_q;
    inv_cnt_d    = inv_cnt_q;
    case (state_q)
      IDLE: begin
        // Top contact takes priority over a simultaneous side overlap.
        if (valid && top_hit) begin
          state_d      = BOUNCE;
          stomp_d      = 1'b1;
          bounce_d     = 1'b1;
          bounce_cnt_d = BOUNCE_LOAD;
        end else if (valid && side_hit && (lives_q == 4'd1)) begin
          state_d = DEAD;
          lives_d = 4'd0;
          go_d    = 1'b1;
        end else if (valid && side_hit && (lives_q != 4'd0)) begin
          state_d   = HURT;
          lives_d   = lives_q - 4'd1;
          inv_d     = 1'b1;
          inv_cnt_d = INVULN_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      BOUNCE: begin
        stomp_d = 1'b0;
        if (bounce_cnt_q == 16'd0) begin
          bounce_d = 1'b0;
          state_d  = IDLE;
        end else begin
          bounce_cnt_d = bounce_cnt_q - 16'd1;
        end
      end
      HURT: begin
        if (inv_cnt_q == 16'd0) begin
          inv_d   = 1'b0;
          state_d = IDLE;
        end else begin
          inv_cnt_d = inv_cnt_q - 16'd1;
        end
      end
      DEAD: begin
        stomp_d  = 1'b0;
        bounce_d = 1'b0;
        inv_d    = 1'b0;
        lives_d  = 4'd0;
        go_d     = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge movement_clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      stomp_q      <= 1'b0;
      bounce_q     <= 1'b0;
      inv_q        <= 1'b0;
      go_q         <= 1'b0;
      lives_q      <= LIVES_LOAD;
      bounce_cnt_q <= 16'd0;
      inv_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      stomp_q      <= stomp_d;
      bounce_q     <= bounce_d;
      inv_q        <= inv_d;
      go_q         <= go_d;
      lives_q      <= lives_d;
      bounce_cnt_q <= bounce_cnt_d;
      inv_cnt_q    <= inv_cnt_d;
    end
  end

  assign stomp      = stomp_q;
  assign bounce_up  = bounce_q;
  assign invincible = inv_q;
  assign lives      = lives_q;
  assign game_over  = go_q;

`ifdef SCORE_EN
  logic [13:0] score_q, score_d;
  logic [14:0] score_sum;

  // Score credits on the same edge that launches the stomp, saturating at 9999.
  always_comb begin
    score_sum = {1'b0, score_q} + 15'(STOMP_POINTS);
    if ((state_q == IDLE) && (state_d == BOUNCE)) begin
      score_d = (score_sum > 15'd9999) ? 14'd9999 : score_sum[13:0];
    end else begin
      score_d = score_q;
    end
  end

  always_ff @(posedge movement_clock or negedge reset) begin
    if (!reset) begin
      score_q <= 14'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = 14'd0;
`endif

endmodule

// File: tb/tb_mario_enemy_contact_responder.sv
// Directed bench for mario_enemy_contact_responder with a tick-budget behavioural model and per-cycle compare.
module tb_mario_enemy_contact_responder;
  localparam int CWID = 42;
  localparam int BT   = 24;
  localparam int IT   = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   mx = 0, my = 0, ex = 300, ey = 398;
  logic alive = 1'b1;
  logic stomp, bounce_up, invincible, game_over;
  logic [3:0]  lives;
  logic [13:0] score;

  int checks = 0;
  int failures = 0;

  mario_enemy_contact_responder dut (
    .movement_clock(clk), .reset(rst_n),
    .mario_x(mx), .mario_y(my), .enemy_x(ex), .enemy_y(ey),
    .enemy_alive(alive), .stomp(stomp), .bounce_up(bounce_up),
    .invincible(invincible), .lives(lives), .game_over(game_over), .score(score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining ticks of each effect, not a state machine.
  int m_lives = 3, m_bleft = 0, m_ileft = 0, m_score = 0;
  bit m_dead = 0, m_stomp = 0;

  always @(posedge clk or negedge rst_n) begin
    bit hx, top, side, v;
    if (!rst_n) begin
      m_lives = 3; m_bleft = 0; m_ileft = 0; m_score = 0; m_dead = 0; m_stomp = 0;
    end else begin
      hx   = (mx + CWID >= ex) && (mx <= ex + CWID);
      top  = hx && (my + CWID == ey);
      side = hx && (my + CWID > ey) && (my < ey + CWID);
      v    = alive && (ex < 640);
      m_stomp = 0;
      if (m_dead) begin
        m_lives = 0;
      end else if (m_bleft > 0) begin
        m_bleft--;
      end else if (m_ileft > 0) begin
        m_ileft--;
      end else if (v && top) begin
        m_stomp = 1;
        m_bleft = BT;
        m_score = (m_score + 100 > 9999) ? 9999 : m_score + 100;
      end else if (v && side) begin
        if (m_lives == 1) begin
          m_dead = 1; m_lives = 0;
        end else begin
          m_lives--; m_ileft = IT;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("stomp", stomp, m_stomp);
    chk("bounce_up", bounce_up, m_bleft > 0);
    chk("invincible", invincible, m_ileft > 0);
    chk("lives", lives, m_lives);
    chk("game_over", game_over, m_dead);
`ifdef SCORE_EN
    chk("score", score, m_score);
`else
    chk("score", score, 0);
`endif
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt_b, cnt_s, cnt_i;
    #1 rst_n = 1'b0;
    ticks(3);
    chk("reset_lives", lives, 3);
    chk("reset_go", game_over, 0);
    rst_n = 1'b1;
    ticks(3);

    // Stomp: 356+42 == 398.
    mx = 290; my = 356;
    ticks(1);
    chk("stomp_first", stomp, 1);
    ex = 1000;
    cnt_b = 0; cnt_s = 0;
    for (int i = 0; i < 40; i++) begin
      cnt_b += int'(bounce_up);
      cnt_s += int'(stomp);
      ticks(1);
    end
    chk("bounce_len", cnt_b, 24);
    chk("stomp_len", cnt_s, 1);
    chk("stomp_lives", lives, 3);
`ifdef SCORE_EN
    chk("stomp_score", score, 100);
`endif

    // Side hit held through the whole invulnerability window.
    mx = 0; my = 0; ex = 300;
    ticks(2);
    mx = 260; my = 398;
    ticks(1);
    cnt_i = 0;
    for (int i = 0; i < 130; i++) begin
      cnt_i += int'(invincible);
      chk("hurt_lives_held", lives, 2);
      if (i == 119) mx = 0;
      ticks(1);
    end
    chk("inv_len", cnt_i, 120);

    // Second hit, then fatal third hit.
    mx = 260;
    ticks(1);
    chk("second_hit", lives, 1);
    mx = 0;
    ticks(125);
    mx = 260;
    ticks(1);
    chk("dead_lives", lives, 0);
    chk("dead_go", game_over, 1);
    mx = 0;
    ticks(200);
    chk("dead_sticky", game_over, 1);
    rst_n = 1'b0;
    ticks(1);
    rst_n = 1'b1;
    ticks(1);
    chk("revive_lives", lives, 3);
    chk("revive_go", game_over, 0);

    // Invalid enemy: dead, then off-screen.
    alive = 1'b0;
    mx = 290; my = 356; ticks(3);
    mx = 260; my = 398; ticks(3);
    chk("dead_enemy_lives", lives, 3);
    alive = 1'b1; ex = 1000;
    mx = 990; my = 356; ticks(3);
    chk("offscreen_stomp", stomp, 0);
    mx = 960; my = 398; ticks(3);
    chk("offscreen_lives", lives, 3);

    // Async reset in the middle of a bounce.
    mx = 290; my = 356; ex = 300;
    ticks(1);
    ex = 1000;
    ticks(10);
    chk("mid_bounce", bounce_up, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_bounce", bounce_up, 0);
    ticks(1);
    rst_n = 1'b1;
    ticks(2);
    chk("post_reset_bounce", bounce_up, 0);

`ifdef SCORE_EN
    for (int k = 0; k < 101; k++) begin
      ex = 300; mx = 290; my = 356;
      ticks(1);
      ex = 1000;
      ticks(26);
    end
    chk("score_sat", score, 9999);
`endif

    ticks(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
